rv_run_monitor: RTL

RV_RUN_MONITOR -- requirements
Module: rv_run_monitor

---
 rtl/rv_mon_pkg.sv | 15 +
 rtl/sat_counter.sv | 21 ++
 rtl/rv_run_monitor.sv | 117 +++++++++++
 3 files changed

// File: rtl/rv_mon_pkg.sv
// Shared types and constants for the CPU run monitor.
// Pure declarations; no timing or flow control involved.
package rv_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } mon_state_t;

    // jal x0,0 : the program spins on itself when finished
    localparam logic [31:0] HALT_JAL_SELF = 32'h0000006F;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; count updates one clk after enable.
// No flow control; clear wins over enable, holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/rv_run_monitor.sv
// Watches a CPU run until halt or timeout, then walks the regfile against an expected table.
// Status registered one clk after each event; no backpressure, start is ignored while busy.
module rv_run_monitor
    import rv_mon_pkg::*;
#(
    parameter int          XLEN       = 32,
    parameter int          MAX_CYCLES = 1000,
    parameter int          NUM_CHECKS = 32,
    parameter int          CNT_W      = 16,
    parameter logic [31:0] HALT_INSTR = HALT_JAL_SELF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [31:0]     instr_val,
    input  logic            ir_write_val,
    input  logic [XLEN-1:0] pc_val,
    output logic [4:0]      chk_addr,
    input  logic [XLEN-1:0] chk_data,
    input  logic [XLEN-1:0] exp_data,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count,
    output logic [XLEN-1:0] halt_pc,
    output logic [5:0]      mismatch_count,
    output logic [4:0]      first_fail_addr,
    output logic            done,
    output logic            pass,
    output logic            timeout
);

    // The timeout uses its own full-range counter so it still fires when the
    // visible cycle_count is narrow enough to saturate first.
    localparam int             TW       = $clog2(MAX_CYCLES);
    localparam logic [TW-1:0]  RUN_LAST = TW'(MAX_CYCLES - 1);
    localparam logic [4:0]     CHK_LAST = 5'(NUM_CHECKS - 1);

    mon_state_t      state_q, state_d;
    logic [TW-1:0]   run_cnt;
    logic            arm, in_run, in_check;
    logic            halt_hit, run_expired, chk_last, mism;

    assign in_run      = (state_q == ST_RUN);
    assign in_check    = (state_q == ST_CHECK);
    assign arm         = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign halt_hit    = in_run && ir_write_val && (instr_val == HALT_INSTR);
    assign run_expired = in_run && (run_cnt == RUN_LAST);
    assign chk_last    = in_check && (chk_addr == CHK_LAST);
    assign mism        = in_check && (chk_data != exp_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_RUN;
            ST_RUN:           if (halt_hit || run_expired) state_d = ST_CHECK;
            ST_CHECK:         if (chk_last) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || arm) begin
            run_cnt         <= '0;
            chk_addr        <= '0;
            halt_pc         <= '0;
            timeout         <= 1'b0;
            mismatch_count  <= '0;
            first_fail_addr <= '0;
        end else begin
            if (in_run) begin
                run_cnt <= run_cnt + 1'b1;
            end
            // halt beats timeout when both land on the same cycle
            if (halt_hit) begin
                halt_pc <= pc_val;
            end else if (run_expired) begin
                timeout <= 1'b1;
            end
            if (in_check) begin
                chk_addr <= chk_last ? 5'd0 : chk_addr + 5'd1;
                if (mism) begin
                    mismatch_count <= mismatch_count + 6'd1;
                    if (mismatch_count == 6'd0) begin
                        first_fail_addr <= chk_addr;
                    end
                end
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (arm),
        .en    (in_run),
        .count (cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_instr_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (arm),
        .en    (in_run && ir_write_val),
        .count (instr_count)
    );

    assign done = (state_q == ST_DONE);
    assign pass = done && (mismatch_count == 6'd0) && !timeout;

endmodule
